// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 load/store encodings and FSM states for the LSU
package lsu_pkg;
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: error detection, store lane strobes/replication and load extraction
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]  op,
  input  logic        wen,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        err,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {off, 3'b000};
    err = !(op inside {OP_B, OP_H, OP_W, OP_BU, OP_HU}) || (wen && op[2]) ||
          (op[1:0] == 2'b01 && off[0]) || (op[1:0] == 2'b10 && off != 2'b00);
    wstrb = op[1:0] == 2'b00 ? 4'b0001 << off : op[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    wdata_rep = op[1:0] == 2'b00 ? {4{wdata[7:0]}} : op[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    rdata_ext = op == OP_B  ? {{24{sh[7]}}, sh[7:0]} :
                op == OP_BU ? {24'b0, sh[7:0]} :
                op == OP_H  ? {{16{sh[15]}}, sh[15:0]} :
                op == OP_HU ? {16'b0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit, IDLE -> ACCESS -> RESP handshake FSM
module lsu import lsu_pkg::*; (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic        dmem_ren,
  output logic [31:0] dmem_raddr,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_wen,
  output logic [31:0] dmem_waddr,
  output logic [31:0] dmem_wstrb,
  output logic [31:0] dmem_wdata
);
  state_t state;
  logic wen, err, xfer, access;
  logic [2:0] op;
  logic [31:0] addr, wdata, wdata_rep, rdata_ext;
  logic [4:0] rd;
  logic [3:0] wstrb;
  lsu_align u_align (.op, .wen, .off(addr[1:0]), .wdata, .rdata(dmem_rdata), .err, .wstrb, .wdata_rep, .rdata_ext);
  assign req_ready = state == IDLE || (state == RESP && resp_ready);
  assign xfer = req_valid && req_ready;
  // memory strobes decode straight from state so an async reset kills them at once
  assign access = state == ACCESS && !err;
  assign dmem_ren = access && !wen;
  assign dmem_wen = access && wen;
  assign dmem_raddr = dmem_ren ? {addr[31:2], 2'b00} : 32'b0;
  assign dmem_waddr = dmem_wen ? {addr[31:2], 2'b00} : 32'b0;
  assign dmem_wstrb = dmem_wen ? {28'b0, wstrb} : 32'b0;
  assign dmem_wdata = dmem_wen ? wdata_rep : 32'b0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      wen <= 1'b0;
      op <= 3'b0;
      addr <= 32'b0;
      wdata <= 32'b0;
      rd <= 5'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'b0;
      resp_rd <= 5'b0;
      resp_err <= 1'b0;
    end else begin
      if (xfer) begin
        state <= ACCESS;
        wen <= req_wen;
        op <= req_op;
        addr <= req_addr;
        wdata <= req_wdata;
        rd <= req_rd;
      end
      if (state == ACCESS) begin
        state <= RESP;
        resp_valid <= 1'b1;
        resp_rdata <= (err || wen) ? 32'b0 : rdata_ext;
        resp_rd <= rd;
        resp_err <= err;
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        if (!xfer) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vector table plus hand sequences for stall, back-to-back and reset
module tb_lsu;
  typedef struct {
    logic        wen;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] word;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b0;
  logic [2:0] req_op = 3'b0;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0, rd_word = 32'b0;
  logic [4:0] req_rd = 5'b0;
  logic req_ready, resp_valid, resp_err, dmem_ren, dmem_wen;
  logic [31:0] resp_rdata, dmem_raddr, dmem_waddr, dmem_wstrb, dmem_wdata;
  logic [4:0] resp_rd;
  int n_cmp = 0, n_bad = 0, wen_cnt = 0, ren_cnt = 0;
  logic [31:0] w_addr = 32'b0, w_strb = 32'b0, w_data = 32'b0, r_addr = 32'b0;
  vec_t vecs[17];

  lsu dut (.clock, .reset, .req_valid, .req_ready, .req_wen, .req_op, .req_addr, .req_wdata, .req_rd,
           .resp_valid, .resp_ready, .resp_rdata, .resp_rd, .resp_err, .dmem_ren, .dmem_raddr,
           .dmem_rdata(rd_word), .dmem_wen, .dmem_waddr, .dmem_wstrb, .dmem_wdata);

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (dmem_wen) begin
      wen_cnt++;
      w_addr = dmem_waddr;
      w_strb = dmem_wstrb;
      w_data = dmem_wdata;
    end
    if (dmem_ren) begin
      ren_cnt++;
      r_addr = dmem_raddr;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    req_valid = 1'b1;
    req_wen = w;
    req_op = o;
    req_addr = a;
    req_wdata = d;
    req_rd = r;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int w0, r0;
    logic ok_ld, ok_st;
    ok_ld = !v.wen && !v.exp_err;
    ok_st = v.wen && !v.exp_err;
    @(negedge clock);
    drive(v.wen, v.op, v.addr, v.wdata, v.rd);
    rd_word = v.word;
    check($sformatf("v%0d_req_ready", i), req_ready, 1);
    w0 = wen_cnt;
    r0 = ren_cnt;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check($sformatf("v%0d_access_valid", i), resp_valid, 0);
    check($sformatf("v%0d_ren", i), dmem_ren, ok_ld);
    check($sformatf("v%0d_wen", i), dmem_wen, ok_st);
    @(negedge clock);
    check($sformatf("v%0d_resp_valid", i), resp_valid, 1);
    check($sformatf("v%0d_rdata", i), resp_rdata, v.exp_rdata);
    check($sformatf("v%0d_err", i), resp_err, v.exp_err);
    check($sformatf("v%0d_rd", i), resp_rd, v.rd);
    check($sformatf("v%0d_ren_cycles", i), ren_cnt - r0, ok_ld);
    check($sformatf("v%0d_wen_cycles", i), wen_cnt - w0, ok_st);
    if (ok_st) begin
      check($sformatf("v%0d_waddr", i), w_addr, {v.addr[31:2], 2'b00});
      check($sformatf("v%0d_wstrb", i), w_strb, {28'b0, v.exp_strb});
      check($sformatf("v%0d_wdata", i), w_data, v.exp_wdata);
    end
    if (ok_ld) check($sformatf("v%0d_raddr", i), r_addr, {v.addr[31:2], 2'b00});
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w0, r0;
    vecs = '{
      '{1'b0, 3'b000, 32'h80000002, 32'h0, 5'd1,  32'h12F45678, 32'hFFFFFFF4, 1'b0, 4'h0, 32'h0},
      '{1'b0, 3'b100, 32'h80000002, 32'h0, 5'd2,  32'h12F45678, 32'h000000F4, 1'b0, 4'h0, 32'h0},
      '{1'b0, 3'b001, 32'h80000002, 32'h0, 5'd3,  32'h12F45678, 32'h000012F4, 1'b0, 4'h0, 32'h0},
      '{1'b0, 3'b101, 32'h80000000, 32'h0, 5'd4,  32'h1234ABCD, 32'h0000ABCD, 1'b0, 4'h0, 32'h0},
      '{1'b0, 3'b001, 32'h80000000, 32'h0, 5'd5,  32'h1234ABCD, 32'hFFFFABCD, 1'b0, 4'h0, 32'h0},
      '{1'b0, 3'b010, 32'h80000004, 32'h0, 5'd6,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 4'h0, 32'h0},
      '{1'b0, 3'b000, 32'h80000001, 32'h0, 5'd7,  32'h000080FF, 32'hFFFFFF80, 1'b0, 4'h0, 32'h0},
      '{1'b0, 3'b001, 32'h80000001, 32'h0, 5'd8,  32'hFFFFFFFF, 32'h0,        1'b1, 4'h0, 32'h0},
      '{1'b0, 3'b010, 32'h80000002, 32'h0, 5'd9,  32'hFFFFFFFF, 32'h0,        1'b1, 4'h0, 32'h0},
      '{1'b0, 3'b011, 32'h80000000, 32'h0, 5'd10, 32'hFFFFFFFF, 32'h0,        1'b1, 4'h0, 32'h0},
      '{1'b1, 3'b000, 32'h80000003, 32'h000000A5, 5'd11, 32'h0, 32'h0, 1'b0, 4'h8, 32'hA5A5A5A5},
      '{1'b1, 3'b001, 32'h80000002, 32'h1234BEEF, 5'd12, 32'h0, 32'h0, 1'b0, 4'hC, 32'hBEEFBEEF},
      '{1'b1, 3'b010, 32'h80000008, 32'hDEADBEEF, 5'd13, 32'h0, 32'h0, 1'b0, 4'hF, 32'hDEADBEEF},
      '{1'b1, 3'b010, 32'h80000006, 32'hDEADBEEF, 5'd14, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0},
      '{1'b1, 3'b100, 32'h80000000, 32'h000000FF, 5'd15, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0},
      '{1'b1, 3'b000, 32'h80000001, 32'h00000077, 5'd16, 32'h0, 32'h0, 1'b0, 4'h2, 32'h77777777},
      '{1'b0, 3'b100, 32'h80000003, 32'h0, 5'd17, 32'h9A000000, 32'h0000009A, 1'b0, 4'h0, 32'h0}
    };
    #2;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_rd", resp_rd, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_ren", dmem_ren, 0);
    check("rst_wen", dmem_wen, 0);
    check("rst_waddr", dmem_waddr, 0);
    check("rst_wstrb", dmem_wstrb, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i], i);

    // stall: response held for three cycles while another request waits
    @(negedge clock);
    drive(1'b0, 3'b010, 32'h80000004, 32'h0, 5'd20);
    rd_word = 32'h0BADF00D;
    @(posedge clock);
    #1 drive(1'b0, 3'b010, 32'h80000008, 32'h0, 5'd21);
    @(negedge clock);
    @(posedge clock);
    #1 rd_word = 32'hFFFFFFFF;
    r0 = ren_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("hold%0d_valid", k), resp_valid, 1);
      check($sformatf("hold%0d_rdata", k), resp_rdata, 32'h0BADF00D);
      check($sformatf("hold%0d_rd", k), resp_rd, 20);
      check($sformatf("hold%0d_req_ready", k), req_ready, 0);
      check($sformatf("hold%0d_ren", k), dmem_ren, 0);
    end
    check("hold_ren_cycles", ren_cnt - r0, 0);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    @(negedge clock);
    check("hold_release_valid", resp_valid, 0);

    // back-to-back loads: second accepted in the first's RESP cycle
    drive(1'b0, 3'b010, 32'h80000000, 32'h0, 5'd5);
    rd_word = 32'h11111111;
    @(posedge clock);
    #1 drive(1'b0, 3'b010, 32'h80000004, 32'h0, 5'd9);
    resp_ready = 1'b1;
    @(negedge clock);
    check("b2b_access1_valid", resp_valid, 0);
    @(negedge clock);
    check("b2b_resp1_valid", resp_valid, 1);
    check("b2b_resp1_rd", resp_rd, 5);
    check("b2b_resp1_rdata", resp_rdata, 32'h11111111);
    check("b2b_resp1_req_ready", req_ready, 1);
    rd_word = 32'h22222222;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("b2b_access2_valid", resp_valid, 0);
    check("b2b_access2_ren", dmem_ren, 1);
    check("b2b_access2_raddr", dmem_raddr, 32'h80000004);
    @(negedge clock);
    check("b2b_resp2_valid", resp_valid, 1);
    check("b2b_resp2_rd", resp_rd, 9);
    check("b2b_resp2_rdata", resp_rdata, 32'h22222222);
    @(posedge clock);
    #1 resp_ready = 1'b0;

    // reset pulse in the ACCESS cycle of a store
    @(negedge clock);
    drive(1'b1, 3'b010, 32'h80000010, 32'h00000055, 5'd3);
    @(posedge clock);
    #1 req_valid = 1'b0;
    #1 check("rstmid_wen_before", dmem_wen, 1);
    w0 = wen_cnt;
    #1 reset = 1'b1;
    #1;
    check("rstmid_wen", dmem_wen, 0);
    check("rstmid_waddr", dmem_waddr, 0);
    check("rstmid_wstrb", dmem_wstrb, 0);
    check("rstmid_wdata", dmem_wdata, 0);
    check("rstmid_req_ready", req_ready, 1);
    check("rstmid_resp_valid", resp_valid, 0);
    check("rstmid_resp_rd", resp_rd, 0);
    @(posedge clock);
    #1 check("rstmid_no_write", wen_cnt - w0, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rstmid_resp_valid_after", resp_valid, 0);
    run_vec(vecs[0], 100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
